mem_port_arbiter: RTL

- Shares the single read/write data port (read port 1 plus write port) of the dual-read pipeline memory between two requesters:
  - the CPU data stage (high priority)
  - an external master (UART loader / debug, low priority)
- Read port 0, the fetch port, is not touched by this block.
- Same-cycle grant; read data returns one cycle after grant, matching the memory's registered read.
- Starvation of the external master is bounded by a burst counter.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for memory read port 1 + write port: CPU data stage (high priority) vs external master.
// Optional MEM_PORT_ARBITER_LOCK_EN adds ext_lock for atomic external read-modify-write.

module mem_port_arbiter_req #(
  parameter int DW = 16
) (
  input  logic          rst,
  input  logic          pick_i,
  input  logic          we_i,
  input  logic          stall_i,
  input  logic          owner_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          gnt_o,
  output logic          rd_set_o,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o
);
  // A read cannot launch while the memory holds its output register; writes always can.
  assign gnt_o    = pick_i & (we_i | ~stall_i) & ~rst;
  assign rd_set_o = gnt_o & ~we_i;
  assign rvalid_o = owner_i;
  assign rdata_o  = owner_i ? mem_rdata_i : '0;
endmodule

module mem_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
`ifdef MEM_PORT_ARBITER_LOCK_EN
  input  logic          ext_lock,
`endif
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  input  logic          mem_stall,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata
);
  localparam int NREQ = 2;
  localparam int CPU  = 0;
  localparam int EXT  = 1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  logic [NREQ-1:0]         pick, we, gnt, rd_set, rvalid;
  logic [NREQ-1:0][DW-1:0] rdata;
  logic [NREQ-1:0]         rd_owner_q, rd_owner_d;
  logic [7:0]              burst_q, burst_d;
  logic                    burst_full;
  logic                    lock_q;

  assign we = {ext_we, cpu_we};

`ifdef MEM_PORT_ARBITER_LOCK_EN
  logic lock_d;

  always_comb begin
    lock_d = lock_q;
    if (!ext_lock)    lock_d = 1'b0;
    else if (gnt[EXT]) lock_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`else
  assign lock_q = 1'b0;
`endif

  // While locked the port belongs to the external master outright, so it also wins the pick.
  assign burst_full = (burst_q == BURST_MAX);
  assign pick[EXT]  = ext_req & (~cpu_req | burst_full | lock_q);
  assign pick[CPU]  = cpu_req & ~pick[EXT] & ~lock_q;

  for (genvar r = 0; r < NREQ; r++) begin : g_req
    mem_port_arbiter_req #(.DW(DW)) u_req (
      .rst         (rst),
      .pick_i      (pick[r]),
      .we_i        (we[r]),
      .stall_i     (mem_stall),
      .owner_i     (rd_owner_q[r]),
      .mem_rdata_i (mem_rdata),
      .gnt_o       (gnt[r]),
      .rd_set_o    (rd_set[r]),
      .rvalid_o    (rvalid[r]),
      .rdata_o     (rdata[r])
    );
  end

  assign cpu_gnt    = gnt[CPU];
  assign ext_gnt    = gnt[EXT];
  assign cpu_rvalid = rvalid[CPU];
  assign ext_rvalid = rvalid[EXT];
  assign cpu_rdata  = rdata[CPU];
  assign ext_rdata  = rdata[EXT];

  // Idle port parks on the CPU address so the next CPU read sees a stable address.
  always_comb begin
    mem_raddr = cpu_addr;
    mem_waddr = cpu_addr;
    mem_wdata = cpu_wdata;
    if (gnt[EXT]) begin
      mem_raddr = ext_addr;
      mem_waddr = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign mem_wen = |(gnt & we);

  always_comb begin
    burst_d = burst_q;
    if (lock_q)                          burst_d = burst_q;
    else if (!ext_req || gnt[EXT])       burst_d = 8'd0;
    else if (gnt[CPU] && !burst_full)    burst_d = burst_q + 8'd1;
  end

  assign rd_owner_d = rd_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q    <= 8'd0;
      rd_owner_q <= '0;
    end else begin
      burst_q    <= burst_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule
